// File: rtl/rom_reader_23128.sv
// Bus-master reader for a 16K x 8 23128-style ROM. Accepts a start address
// and burst length, sequences the chip strobes with programmable access and
// recovery wait states, and returns one byte per valid/ready handshake.
`timescale 1ns/1ps
module rom_reader_23128 #(
  parameter int ACCESS_CYCLES   = 3,  // strobes-low cycles before D is sampled, 1..15
  parameter int RECOVERY_CYCLES = 1,  // strobes-high gap between burst bytes, 0..15
  parameter int LEN_W           = 4   // burst length is req_len + 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [13:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_last,
  output logic             busy,
  output logic [13:0]      A,
  input  logic [7:0]       D,
  output logic             CS_b,
  output logic             OE_b,
  output logic             CE1_b,
  output logic             CE2_b,
  output logic             WE_b
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP,
    RECOVER
  } state_t;

  // Wait counters count down to zero, so they are loaded with N-1.
  localparam logic [3:0] ACC_LOAD     = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] REC_LOAD     = (RECOVERY_CYCLES > 0) ? 4'(RECOVERY_CYCLES - 1) : 4'd0;
  localparam bit         HAS_RECOVERY = (RECOVERY_CYCLES > 0);

  state_t           state;
  state_t           next_state;
  logic [3:0]       wait_cnt;
  logic [LEN_W-1:0] remaining;
  logic [13:0]      addr_q;
  logic [7:0]       data_q;
  logic             cs_q;
  logic             oe_q;

  logic rsp_fire;
  assign rsp_fire = (state == RESP) && rsp_ready;

  // Next-state decode for the read sequencer.
  always_comb begin
    // NOTE: default assignment first so every path drives next_state and no latch is inferred.
    next_state = state;
    unique case (state)
      IDLE:    if (req_valid) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (wait_cnt == 4'd0) next_state = RESP;
      RESP: begin
        if (rsp_ready) begin
          if (remaining == '0)    next_state = IDLE;
          else if (HAS_RECOVERY)  next_state = RECOVER;
          else                    next_state = SETUP;
        end
      end
      RECOVER: if (wait_cnt == 4'd0) next_state = SETUP;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_b) state <= IDLE;
    else        state <= next_state;
  end

  // Datapath: address, burst count, wait counter, captured byte and strobes.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      addr_q    <= 14'd0;
      remaining <= '0;
      wait_cnt  <= 4'd0;
      data_q    <= 8'd0;
      // NOTE: strobes reset high (inactive) so the ROM is deselected out of reset.
      cs_q      <= 1'b1;
      oe_q      <= 1'b1;
    end else begin
      // Strobes are registered from the next state so they change only on
      // the clock edge and never glitch.
      cs_q <= !((next_state == SETUP) || (next_state == ACCESS));
      oe_q <= !(next_state == ACCESS);

      unique case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            remaining <= req_len;
          end
        end
        SETUP: wait_cnt <= ACC_LOAD;
        ACCESS: begin
          if (wait_cnt == 4'd0) data_q   <= D;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        RESP: begin
          // Address advances only here, while CS_b is high.
          if (rsp_fire && (remaining != '0)) begin
            remaining <= remaining - LEN_W'(1);
            addr_q    <= addr_q + 14'd1;
            wait_cnt  <= REC_LOAD;
          end
        end
        RECOVER: begin
          if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_last  = (state == RESP) && (remaining == '0);
  assign rsp_data  = data_q;
  assign A         = addr_q;
  assign CS_b      = cs_q;
  assign OE_b      = oe_q;
  assign CE1_b     = oe_q;
  assign CE2_b     = oe_q;
  assign WE_b      = 1'b1;

endmodule

// File: tb/tb_rom_reader_23128.sv
// Self-checking bench for rom_reader_23128: a default-parameter instance and
// a fast instance (ACCESS_CYCLES=1, RECOVERY_CYCLES=0), each with a ROM model
// and a scoreboard queue popped by an independent monitor.
`timescale 1ns/1ps
module tb_rom_reader_23128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_b;

  // Default-parameter instance.
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_last, busy;
  logic        cs_b, oe_b, ce1_b, ce2_b, we_b;
  logic [13:0] req_addr, a;
  logic [3:0]  req_len;
  logic [7:0]  rsp_data, d;

  // Fast instance.
  logic        f_req_valid, f_req_ready, f_rsp_valid, f_rsp_ready, f_rsp_last, f_busy;
  logic        f_cs_b, f_oe_b, f_ce1_b, f_ce2_b, f_we_b;
  logic [13:0] f_req_addr, f_a;
  logic [3:0]  f_req_len;
  logic [7:0]  f_rsp_data, f_d;

  logic [7:0] rom [16384];
  assign d   = rom[a];
  assign f_d = rom[f_a];

  // Backpressure: directed value or a random one during the soak phase.
  logic dir_ready, rnd_ready, rnd_bp;
  assign rsp_ready   = rnd_bp ? rnd_ready : dir_ready;
  assign f_rsp_ready = 1'b1;

  rom_reader_23128 dut (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .busy(busy), .A(a), .D(d),
    .CS_b(cs_b), .OE_b(oe_b), .CE1_b(ce1_b), .CE2_b(ce2_b), .WE_b(we_b)
  );

  rom_reader_23128 #(.ACCESS_CYCLES(1), .RECOVERY_CYCLES(0), .LEN_W(4)) dut_fast (
    .clk(clk), .rst_b(rst_b),
    .req_valid(f_req_valid), .req_ready(f_req_ready), .req_addr(f_req_addr), .req_len(f_req_len),
    .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_data(f_rsp_data), .rsp_last(f_rsp_last),
    .busy(f_busy), .A(f_a), .D(f_d),
    .CS_b(f_cs_b), .OE_b(f_oe_b), .CE1_b(f_ce1_b), .CE2_b(f_ce2_b), .WE_b(f_we_b)
  );

  typedef struct packed {
    logic [7:0]  data;
    logic        last;
    logic [13:0] addr;
  } exp_t;

  exp_t sb[$];
  exp_t f_sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event did not occur within its bound", name);
  endtask

  // Strobe-low cycle counters, zeroed by the driver while idle.
  int cs_cnt, oe_cnt, f_cs_cnt, f_oe_cnt;
  always @(negedge clk) begin
    if (!cs_b)   cs_cnt++;
    if (!oe_b)   oe_cnt++;
    if (!f_cs_b) f_cs_cnt++;
    if (!f_oe_b) f_oe_cnt++;
  end

  always @(negedge clk) rnd_ready = ($urandom_range(0, 3) != 0);

  // Monitor for the default instance: scoreboard, stall stability, strobe rules.
  logic        stall_prev = 1'b0;
  logic [7:0]  stall_data;
  logic        stall_last;
  logic [13:0] stall_a;
  logic        cs_prev = 1'b1;
  logic [13:0] a_prev = 14'd0;
  exp_t        m_exp;
  always @(negedge clk) begin
    #1;
    if (rst_b) begin
      if (stall_prev) begin
        check("stall_valid", 32'(rsp_valid), 32'd1);
        check("stall_data",  32'(rsp_data),  32'(stall_data));
        check("stall_last",  32'(rsp_last),  32'(stall_last));
        check("stall_addr",  32'(a),         32'(stall_a));
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) fail_now("stray_response");
        else begin
          m_exp = sb.pop_front();
          check("rsp_data", 32'(rsp_data), 32'(m_exp.data));
          check("rsp_last", 32'(rsp_last), 32'(m_exp.last));
          check("rsp_addr", 32'(a),        32'(m_exp.addr));
        end
      end
      if (!oe_b)         check("oe_implies_cs", 32'(cs_b), 32'd0);
      if (!oe_b || !ce1_b || !ce2_b)
        check("ce_track_oe", 32'({ce1_b, ce2_b}), 32'({oe_b, oe_b}));
      if (!cs_b && !cs_prev) check("addr_stable_cs", 32'(a), 32'(a_prev));
      stall_prev = rsp_valid && !rsp_ready;
      stall_data = rsp_data;
      stall_last = rsp_last;
      stall_a    = a;
    end else begin
      stall_prev = 1'b0;
    end
    cs_prev = cs_b;
    a_prev  = a;
  end

  // Monitor for the fast instance.
  exp_t f_exp;
  always @(negedge clk) begin
    #1;
    if (rst_b && f_rsp_valid && f_rsp_ready) begin
      if (f_sb.size() == 0) fail_now("fast_stray_response");
      else begin
        f_exp = f_sb.pop_front();
        check("fast_rsp_data", 32'(f_rsp_data), 32'(f_exp.data));
        check("fast_rsp_last", 32'(f_rsp_last), 32'(f_exp.last));
        check("fast_rsp_addr", 32'(f_a),        32'(f_exp.addr));
      end
    end
    if (rst_b && !f_oe_b) check("fast_oe_implies_cs", 32'(f_cs_b), 32'd0);
  end

  // Issue one request and push the bytes the ROM model says it must return.
  task automatic issue_req(input bit sel, input logic [13:0] addr, input logic [3:0] len);
    int   waited = 0;
    exp_t e;
    @(negedge clk);
    while (!(sel ? f_req_ready : req_ready) && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 3000) begin
      fail_now("req_ready_wait");
      return;
    end
    for (int i = 0; i <= int'(len); i++) begin
      e.addr = 14'((int'(addr) + i) % 16384);
      e.data = rom[e.addr];
      e.last = (i == int'(len));
      if (sel) f_sb.push_back(e);
      else     sb.push_back(e);
    end
    if (sel) begin
      f_req_valid = 1'b1; f_req_addr = addr; f_req_len = len;
    end else begin
      req_valid = 1'b1; req_addr = addr; req_len = len;
    end
    @(posedge clk);
    #1;
    if (sel) f_req_valid = 1'b0;
    else     req_valid   = 1'b0;
  endtask

  // Count falling edges until rsp_valid is seen (at least one step).
  task automatic wait_valid(input bit sel, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sel ? f_rsp_valid : rsp_valid) && n < 300);
    if (!(sel ? f_rsp_valid : rsp_valid)) fail_now("rsp_valid_wait");
  endtask

  task automatic drain(input bit sel);
    int w = 0;
    while (((sel ? f_sb.size() : sb.size()) != 0 || !(sel ? f_req_ready : req_ready)) && w < 8000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 8000) fail_now("drain");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int            n, strays;
  logic [7:0]    wrap_bytes [4];
  logic [13:0]   fa;

  initial begin
    for (int i = 0; i < 16384; i++) rom[i] = 8'($urandom);
    rom[14'h0123] = 8'hA5;
    rom[14'h3FFE] = 8'hFE; rom[14'h3FFF] = 8'hFF;
    rom[14'h0000] = 8'h00; rom[14'h0001] = 8'h01;
    wrap_bytes[0] = 8'hFE; wrap_bytes[1] = 8'hFF; wrap_bytes[2] = 8'h00; wrap_bytes[3] = 8'h01;

    req_valid = 1'b0; req_addr = 14'd0; req_len = 4'd0;
    f_req_valid = 1'b0; f_req_addr = 14'd0; f_req_len = 4'd0;
    dir_ready = 1'b1; rnd_bp = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_strobes",   32'({cs_b, oe_b, ce1_b, ce2_b}), 32'hF);
    check("rst_addr",      32'(a),         32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    check("rst_rsp_last",  32'(rsp_last),  32'd0);
    check("we_b",          32'(we_b),      32'd1);
    rst_b = 1'b1;

    // Single read.
    cs_cnt = 0; oe_cnt = 0;
    issue_req(1'b0, 14'h0123, 4'd0);
    wait_valid(1'b0, n);
    check("single_latency", 32'(n), 32'd5);
    check("single_data",    32'(rsp_data), 32'hA5);
    check("single_last",    32'(rsp_last), 32'd1);
    @(negedge clk);
    check("single_idle_ready", 32'(req_ready), 32'd1);
    check("single_idle_busy",  32'(busy),      32'd0);
    check("single_cs_cycles",  32'(cs_cnt),    32'd4);
    check("single_oe_cycles",  32'(oe_cnt),    32'd3);

    // Burst across the top of the address space.
    issue_req(1'b0, 14'h3FFE, 4'd3);
    for (int k = 0; k < 4; k++) begin
      wait_valid(1'b0, n);
      check(k == 0 ? "wrap_latency" : "wrap_gap", 32'(n), k == 0 ? 32'd5 : 32'd6);
      check("wrap_data", 32'(rsp_data), 32'(wrap_bytes[k]));
      check("wrap_addr", 32'(a),        32'((16382 + k) % 16384));
      check("wrap_last", 32'(rsp_last), 32'(k == 3));
    end
    drain(1'b0);

    // Backpressure on the second byte.
    issue_req(1'b0, 14'h3FFE, 4'd3);
    wait_valid(1'b0, n);
    @(negedge clk);
    dir_ready = 1'b0;
    wait_valid(1'b0, n);
    for (int i = 0; i < 10; i++) begin
      check("bp_data",    32'(rsp_data), 32'hFF);
      check("bp_addr",    32'(a),        32'h3FFF);
      check("bp_strobes", 32'({cs_b, oe_b, ce1_b, ce2_b}), 32'hF);
      check("bp_valid",   32'(rsp_valid), 32'd1);
      @(negedge clk);
    end
    dir_ready = 1'b1;
    wait_valid(1'b0, n);
    check("bp_resume_data", 32'(rsp_data), 32'h00);
    wait_valid(1'b0, n);
    check("bp_resume_gap",  32'(n),        32'd6);
    check("bp_final_last",  32'(rsp_last), 32'd1);
    drain(1'b0);

    // Reset during the second access cycle.
    issue_req(1'b0, 14'($urandom), 4'd5);
    repeat (3) @(negedge clk);
    check("mid_access_oe", 32'(oe_b), 32'd0);
    rst_b = 1'b0;
    sb.delete();
    @(negedge clk);
    check("mid_rst_strobes",   32'({cs_b, oe_b, ce1_b, ce2_b}), 32'hF);
    check("mid_rst_addr",      32'(a),         32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    rst_b = 1'b1;
    strays = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid) strays++;
    end
    check("mid_rst_no_stray", 32'(strays), 32'd0);

    // Fast instance: no recovery gap, one access cycle.
    f_cs_cnt = 0; f_oe_cnt = 0;
    fa = 14'($urandom);
    issue_req(1'b1, fa, 4'd1);
    wait_valid(1'b1, n);
    check("fast_latency", 32'(n), 32'd3);
    @(negedge clk);
    check("fast_setup_cs", 32'(f_cs_b), 32'd0);
    check("fast_setup_oe", 32'(f_oe_b), 32'd1);
    wait_valid(1'b1, n);
    check("fast_gap",  32'(n),          32'd2);
    check("fast_last", 32'(f_rsp_last), 32'd1);
    @(negedge clk);
    check("fast_oe_cycles", 32'(f_oe_cnt),    32'd2);
    check("fast_cs_cycles", 32'(f_cs_cnt),    32'd4);
    check("fast_idle",      32'(f_req_ready), 32'd1);
    check("fast_busy",      32'(f_busy),      32'd0);
    check("fast_we_b",      32'(f_we_b),      32'd1);
    check("fast_ce",        32'({f_ce1_b, f_ce2_b}), 32'h3);

    // Request while busy is ignored.
    issue_req(1'b0, 14'h0100, 4'd4);
    repeat (3) @(negedge clk);
    check("busy_req_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b1; req_addr = 14'h2222; req_len = 4'd0;
    @(negedge clk);
    req_valid = 1'b0;
    drain(1'b0);
    repeat (20) @(negedge clk);

    // Randomized soak with random backpressure.
    rnd_bp = 1'b1;
    for (int t = 0; t < 30; t++) begin
      issue_req(1'b0, 14'($urandom), 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain(1'b0);
    rnd_bp = 1'b0;

    repeat (5) @(negedge clk);
    check("sb_empty",      32'(sb.size()),   32'd0);
    check("fast_sb_empty", 32'(f_sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_reader_23128.md
Name: rom_reader_23128

Overview:
Bus-master reader for a 16K x 8 23128-style read-only memory. It accepts a start address and burst length on a valid/ready request port. It drives the ROM chip pins (A, CS_b, OE_b, CE1_b, CE2_b) with programmable access wait states, samples D, and returns bytes one at a time on a valid/ready response port. It sits between the system-side fetch logic and the ROM pin interface.

Parameters:
ACCESS_CYCLES, 3, cycles OE_b/CE1_b/CE2_b are held low before D is sampled; legal range 1..15.
RECOVERY_CYCLES, 1, cycles all strobes are held high between bytes of a burst; legal range 0..15.
LEN_W, 4, width of req_len; burst length is req_len+1 bytes, so the default allows 1..16.

Ports:
clk  input  1  single clock; all logic on rising edge.
rst_b  input  1  synchronous active-low reset.
req_valid  input  1  request present.
req_ready  output  1  reader idle and able to accept a request.
req_addr  input  14  start byte address.
req_len  input  LEN_W  burst length minus one.
rsp_valid  output  1  rsp_data valid.
rsp_ready  input  1  consumer accepts the byte.
rsp_data  output  8  byte read from the ROM.
rsp_last  output  1  marks the final byte of the burst; valid only when rsp_valid=1.
busy  output  1  high in any state other than IDLE.
A  output  14  ROM address pins.
D  input  8  ROM data pins.
CS_b  output  1  chip select, active low.
OE_b  output  1  output enable, active low.
CE1_b  output  1  chip enable 1, active low.
CE2_b  output  1  chip enable 2, active low.
WE_b  output  1  constant 1; the ROM is never written.

Behaviour:
- Reset (rst_b=0 at a clock edge): state=IDLE; CS_b=OE_b=CE1_b=CE2_b=1; A=0; rsp_valid=0; rsp_data=0; rsp_last=0; busy=0; req_ready=1 after reset.
- Reset mid-operation: any state goes to IDLE at that edge. The in-flight burst is discarded and no further rsp_valid is raised for it.
- States: IDLE, SETUP, ACCESS, RESP, RECOVER.
- IDLE:
  - req_ready=1 and all strobes are high.
  - On req_valid&req_ready, latch the address into A and latch remaining=req_len, then go to SETUP.
- SETUP (1 cycle):
  - CS_b=0; OE_b=CE1_b=CE2_b=1.
  - A is stable, then go to ACCESS.
- ACCESS (ACCESS_CYCLES cycles):
  - CS_b=OE_b=CE1_b=CE2_b=0; a wait counter counts down.
  - At the edge ending the last ACCESS cycle, D is registered into rsp_data and the state goes to RESP.
- RESP:
  - All strobes are high; A holds its value.
  - rsp_valid=1 and rsp_last=(remaining==0).
  - rsp_data, rsp_last and A stay stable while rsp_ready=0, for an unbounded stall.
  - On rsp_valid&rsp_ready with remaining==0, go to IDLE.
  - On rsp_valid&rsp_ready with remaining>0: decrement remaining and set A=A+1 modulo 2^14 (3FFF wraps to 0000).
    - If RECOVERY_CYCLES>0, go to RECOVER.
    - Otherwise go straight to SETUP.
- RECOVER (RECOVERY_CYCLES cycles): all strobes are high, then go to SETUP.
- Latency:
  - Request accepted at edge E; first rsp_valid=1 in cycle E+1+1+ACCESS_CYCLES. With defaults, rsp_valid rises in the 5th cycle after acceptance.
  - Per additional byte, with immediate rsp_ready: 1 (handshake) + RECOVERY_CYCLES + 1 + ACCESS_CYCLES cycles. Defaults give 6.
- req_ready=0 outside IDLE; requests presented then are ignored and not queued.
- busy=1 in SETUP/ACCESS/RESP/RECOVER.
- Strobe invariants:
  - OE_b=0 implies CS_b=0.
  - CS_b, OE_b, CE1_b and CE2_b are registered outputs with no glitches.
  - A never changes while CS_b=0.

Test Plan:
- Single read: ROM model holds 8'hA5 at 14'h0123; request addr=0123, len=0, rsp_ready=1 -> CS_b low 4 cycles and OE_b low 3 cycles; rsp_valid in cycle E+5 with data A5 and rsp_last=1; back to IDLE with req_ready=1 the next cycle.
- Burst with wrap: ROM byte = low 8 address bits; request addr=3FFE, len=3 -> bytes FE,FF,00,01 on A 3FFE,3FFF,0000,0001; rsp_last only on the 4th byte; 6 cycles between rsp_valid pulses.
- Backpressure: same burst with rsp_ready low 10 cycles on byte 2 -> rsp_data=FF and A=3FFF held stable, strobes high throughout; burst resumes normally once rsp_ready rises.
- Reset mid-access: rst_b low during the 2nd ACCESS cycle -> next cycle all strobes 1, A=0, rsp_valid=0, req_ready=1; no stray response afterwards.
- Parameter corners: ACCESS_CYCLES=1, RECOVERY_CYCLES=0, len=1 -> first rsp_valid at E+3; after handshake, SETUP follows immediately with no recovery gap; OE_b low exactly 1 cycle per byte.
- Request during busy: req_valid pulsed with a new address mid-burst -> ignored; the original burst completes unchanged.
